// File: rtl/datapath_execute_if.sv
// Avalon-MM data-port bundle between the execute stage (master) and data memory (slave).
interface datapath_execute_if;
  logic [15:0] addr;
  logic        rd;
  logic        wr;
  logic [15:0] wrdata;
  logic        waitrequest;

  modport master (
    output addr,
    output rd,
    output wr,
    output wrdata,
    input  waitrequest
  );

  modport slave (
    input  addr,
    input  rd,
    input  wr,
    input  wrdata,
    output waitrequest
  );
endinterface

// File: rtl/datapath_execute.sv
// Execute stage of the 16-bit 4-stage pipeline: WB bypass, ALU, Z/N flags, ld/st issue with
// waitrequest stalls, branch resolution, and the registered EX_WB payload to writeback.
module datapath_execute #(
  parameter int RF_EX_WIDTH = 64,
  parameter int EX_WB_WIDTH = 64,
  parameter bit FWD_EN      = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RF_EX_WIDTH-1:0] RF_EX,
  input  logic                   i_rf_ex_valid,
  output logic                   o_stall,
  input  logic                   wb_RFWrite,
  input  logic [2:0]             wb_regw,
  input  logic [15:0]            wb_dataw,
  datapath_execute_if.master     ldst,
  output logic                   o_br_taken,
  output logic [15:0]            o_br_target,
  output logic [EX_WB_WIDTH-1:0] EX_WB,
  output logic                   o_ex_wb_valid,
  output logic                   o_flag_z,
  output logic                   o_flag_n
);

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  typedef enum logic {EX_IDLE, EX_MEMWAIT} state_e;

  state_e                   state_q;
  logic [15:0]              op1_q, op2_q;
  logic                     flag_z_q, flag_n_q;
  logic [EX_WB_WIDTH-1:0]   ex_wb_q;
  logic                     ex_wb_valid_q;

  logic [15:0] pc, data1, data2, instr;
  logic [4:0]  op;
  logic [2:0]  rx_idx, ry_idx;
  logic [7:0]  imm8;
  logic [10:0] imm11;
  logic [15:0] fwd1, fwd2;
  logic [15:0] rx_val, ry_val;
  logic [15:0] imm8_sext, br_offset, pc_plus2;

  assign pc     = RF_EX[63:48];
  assign data1  = RF_EX[47:32];
  assign data2  = RF_EX[31:16];
  assign instr  = RF_EX[15:0];
  assign op     = instr[4:0];
  assign rx_idx = instr[7:5];
  assign ry_idx = instr[10:8];
  assign imm8   = instr[15:8];
  assign imm11  = instr[15:5];

  generate
    if (FWD_EN) begin : g_fwd
      assign fwd1 = (wb_RFWrite && (wb_regw == rx_idx)) ? wb_dataw : data1;
      assign fwd2 = (wb_RFWrite && (wb_regw == ry_idx)) ? wb_dataw : data2;
    end else begin : g_nofwd
      logic unused_wb;
      assign unused_wb = ^{wb_RFWrite, wb_regw, wb_dataw, rx_idx, ry_idx};
      assign fwd1      = data1;
      assign fwd2      = data2;
    end
  endgenerate

  // A stalled ld/st keeps the operands it saw when it first issued, regardless of later WB traffic.
  assign rx_val = (state_q == EX_MEMWAIT) ? op1_q : fwd1;
  assign ry_val = (state_q == EX_MEMWAIT) ? op2_q : fwd2;

  assign imm8_sext = {{8{imm8[7]}}, imm8};
  assign br_offset = {{4{imm11[10]}}, imm11, 1'b0};
  assign pc_plus2  = pc + 16'd2;

  logic [15:0] alu_res;
  logic        sets_flags;
  logic        is_branch;
  logic        br_cond;
  logic        br_reg;

  always_comb begin
    alu_res    = 16'h0000;
    sets_flags = 1'b0;
    is_branch  = 1'b0;
    br_cond    = 1'b0;
    br_reg     = 1'b0;
    case (op)
      OP_MV:          alu_res = ry_val;
      OP_ADD:         begin alu_res = rx_val + ry_val;    sets_flags = 1'b1; end
      OP_SUB, OP_CMP: begin alu_res = rx_val - ry_val;    sets_flags = 1'b1; end
      OP_LD, OP_ST:   alu_res = ry_val;
      OP_JR:          begin is_branch = 1'b1; br_cond = 1'b1;     br_reg = 1'b1; end
      OP_JZR:         begin is_branch = 1'b1; br_cond = flag_z_q; br_reg = 1'b1; end
      OP_JNR:         begin is_branch = 1'b1; br_cond = flag_n_q; br_reg = 1'b1; end
      OP_CALLR: begin
        alu_res   = pc_plus2;
        is_branch = 1'b1;
        br_cond   = 1'b1;
        br_reg    = 1'b1;
      end
      OP_MVI:           alu_res = imm8_sext;
      OP_ADDI:          begin alu_res = rx_val + imm8_sext; sets_flags = 1'b1; end
      OP_SUBI, OP_CMPI: begin alu_res = rx_val - imm8_sext; sets_flags = 1'b1; end
      OP_MVHI:          alu_res = {imm8, rx_val[7:0]};
      OP_J:             begin is_branch = 1'b1; br_cond = 1'b1;     end
      OP_JZ:            begin is_branch = 1'b1; br_cond = flag_z_q; end
      OP_JN:            begin is_branch = 1'b1; br_cond = flag_n_q; end
      OP_CALL: begin
        alu_res   = pc_plus2;
        is_branch = 1'b1;
        br_cond   = 1'b1;
      end
      default: ;
    endcase
  end

  logic is_ld, is_st, mem_req, stall, commit;

  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  // All request-side outputs are forced quiet while reset is held low.
  assign mem_req = reset && i_rf_ex_valid && (is_ld || is_st);
  assign stall   = mem_req && ldst.waitrequest;
  assign commit  = reset && i_rf_ex_valid && !stall;

  assign ldst.rd     = mem_req && is_ld;
  assign ldst.wr     = mem_req && is_st;
  assign ldst.addr   = ry_val;
  assign ldst.wrdata = rx_val;

  assign o_stall     = stall;
  assign o_br_taken  = commit && is_branch && br_cond;
  assign o_br_target = br_reg ? rx_val : (pc_plus2 + br_offset);

  logic [EX_WB_WIDTH-1:0] ex_wb_d;
  logic                   flag_z_d, flag_n_d;

  assign ex_wb_d  = {rx_val, ry_val, alu_res, instr};
  assign flag_z_d = sets_flags ? (alu_res == 16'h0000) : flag_z_q;
  assign flag_n_d = sets_flags ? alu_res[15] : flag_n_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= EX_IDLE;
      op1_q         <= 16'h0000;
      op2_q         <= 16'h0000;
      flag_z_q      <= 1'b0;
      flag_n_q      <= 1'b0;
      ex_wb_q       <= '0;
      ex_wb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EX_IDLE: begin
          if (stall) begin
            state_q <= EX_MEMWAIT;
            op1_q   <= fwd1;
            op2_q   <= fwd2;
          end
        end
        EX_MEMWAIT: begin
          if (!stall) state_q <= EX_IDLE;
        end
        default: state_q <= EX_IDLE;
      endcase

      if (commit) begin
        ex_wb_q       <= ex_wb_d;
        ex_wb_valid_q <= 1'b1;
        flag_z_q      <= flag_z_d;
        flag_n_q      <= flag_n_d;
      end else begin
        ex_wb_q       <= '0;
        ex_wb_valid_q <= 1'b0;
      end
    end
  end

  assign EX_WB         = ex_wb_q;
  assign o_ex_wb_valid = ex_wb_valid_q;
  assign o_flag_z      = flag_z_q;
  assign o_flag_n      = flag_n_q;

endmodule

// File: tb/tb_datapath_execute.sv
// Bench for datapath_execute: directed vector table, multi-cycle ld/st/reset sequences, and
// randomized instructions checked against an arithmetic reference model.
module tb_datapath_execute;

  localparam logic [4:0] OP_MV    = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_CMP   = 5'b00011;
  localparam logic [4:0] OP_LD    = 5'b00100;
  localparam logic [4:0] OP_ST    = 5'b00101;
  localparam logic [4:0] OP_JR    = 5'b01000;
  localparam logic [4:0] OP_JZR   = 5'b01001;
  localparam logic [4:0] OP_JNR   = 5'b01010;
  localparam logic [4:0] OP_CALLR = 5'b01100;
  localparam logic [4:0] OP_MVI   = 5'b10000;
  localparam logic [4:0] OP_ADDI  = 5'b10001;
  localparam logic [4:0] OP_SUBI  = 5'b10010;
  localparam logic [4:0] OP_CMPI  = 5'b10011;
  localparam logic [4:0] OP_MVHI  = 5'b10110;
  localparam logic [4:0] OP_J     = 5'b11000;
  localparam logic [4:0] OP_JZ    = 5'b11001;
  localparam logic [4:0] OP_JN    = 5'b11010;
  localparam logic [4:0] OP_CALL  = 5'b11100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rf_ex;
  logic        valid;
  logic        wb_we;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        waitreq;

  logic        stall, br_taken, ex_wb_valid, flag_z, flag_n;
  logic [15:0] br_target;
  logic [63:0] ex_wb;
  logic        stall0, br_taken0, ex_wb_valid0, flag_z0, flag_n0;
  logic [15:0] br_target0;
  logic [63:0] ex_wb0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_execute_if bus ();
  datapath_execute_if bus0 ();
  assign bus.waitrequest  = waitreq;
  assign bus0.waitrequest = 1'b0;

  datapath_execute #(.FWD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .RF_EX(rf_ex), .i_rf_ex_valid(valid), .o_stall(stall),
    .wb_RFWrite(wb_we), .wb_regw(wb_reg), .wb_dataw(wb_data), .ldst(bus),
    .o_br_taken(br_taken), .o_br_target(br_target), .EX_WB(ex_wb),
    .o_ex_wb_valid(ex_wb_valid), .o_flag_z(flag_z), .o_flag_n(flag_n)
  );

  datapath_execute #(.FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .reset(reset), .RF_EX(rf_ex), .i_rf_ex_valid(valid), .o_stall(stall0),
    .wb_RFWrite(wb_we), .wb_regw(wb_reg), .wb_dataw(wb_data), .ldst(bus0),
    .o_br_taken(br_taken0), .o_br_target(br_target0), .EX_WB(ex_wb0),
    .o_ex_wb_valid(ex_wb_valid0), .o_flag_z(flag_z0), .o_flag_n(flag_n0)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {5'b00000, ry, rx, op};
  endfunction
  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rx, input logic [7:0] imm);
    return {imm, rx, op};
  endfunction
  function automatic logic [15:0] enc_j(input logic [4:0] op, input logic [10:0] imm);
    return {imm, op};
  endfunction

  typedef struct packed {
    logic [15:0] rx, ry, alu, target;
    logic        taken, z, n, is_ld, is_st;
  } res_t;

  // Reference behaviour from the instruction-set rules, in plain integer arithmetic.
  function automatic res_t model(input logic [15:0] pc, d1, d2, ins, input logic we,
                                 input logic [2:0] wreg, input logic [15:0] wdata,
                                 input logic z, input logic n);
    res_t m;
    int x, y, imm, off, p, r, t;
    logic setf;
    m    = '0;
    setf = 1'b0;
    r    = 0;
    t    = 0;
    x    = (we && wreg == ins[7:5]) ? int'(wdata) : int'(d1);
    y    = (we && wreg == ins[10:8]) ? int'(wdata) : int'(d2);
    imm  = int'($signed(ins[15:8]));
    off  = int'($signed(ins[15:5])) * 2;
    p    = int'(pc);
    case (ins[4:0])
      OP_MV:   r = y;
      OP_ADD:  begin r = x + y; setf = 1'b1; end
      OP_SUB, OP_CMP: begin r = x - y; setf = 1'b1; end
      OP_LD:   begin r = y; m.is_ld = 1'b1; end
      OP_ST:   begin r = y; m.is_st = 1'b1; end
      OP_JR:   begin m.taken = 1'b1; t = x; end
      OP_JZR:  begin m.taken = z; t = x; end
      OP_JNR:  begin m.taken = n; t = x; end
      OP_CALLR: begin m.taken = 1'b1; t = x; r = p + 2; end
      OP_MVI:  r = imm;
      OP_ADDI: begin r = x + imm; setf = 1'b1; end
      OP_SUBI, OP_CMPI: begin r = x - imm; setf = 1'b1; end
      OP_MVHI: r = int'(ins[15:8]) * 256 + (x % 256);
      OP_J:    begin m.taken = 1'b1; t = p + 2 + off; end
      OP_JZ:   begin m.taken = z; t = p + 2 + off; end
      OP_JN:   begin m.taken = n; t = p + 2 + off; end
      OP_CALL: begin m.taken = 1'b1; t = p + 2 + off; r = p + 2; end
      default: r = 0;
    endcase
    m.rx     = 16'(x);
    m.ry     = 16'(y);
    m.alu    = 16'(r & 32'hFFFF);
    m.target = 16'(t & 32'hFFFF);
    m.z      = setf ? (m.alu == 16'h0000) : z;
    m.n      = setf ? (m.alu >= 16'h8000) : n;
    return m;
  endfunction

  typedef struct packed {
    logic [15:0] pc, d1, d2, instr;
    logic        we;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] e_alu, e_alu_nofwd, e_rx;
    logic        e_taken;
    logic [15:0] e_tgt;
    logic        e_z, e_n;
  } vec_t;

  vec_t vt [14];
  logic [4:0] ops [19];

  logic [15:0] r_pc, r_d1, r_d2, r_ins, r_wd;
  logic        r_we, r_v, mz, mn;
  logic [2:0]  r_wr;
  int          waits;
  res_t        m;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ops = '{OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST, OP_JR, OP_JZR, OP_JNR, OP_CALLR,
            OP_MVI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MVHI, OP_J, OP_JZ, OP_JN, OP_CALL};
    //        pc       d1       d2       instr                          we wreg wdata    alu      alu0     rx      tk tgt     z  n
    vt[0]  = '{16'h0000, 16'hFFFB, 16'h0000, enc_i(OP_ADDI, 3'd1, 8'd5), 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hFFFB, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1]  = '{16'h0002, 16'h0001, 16'h0000, enc_r(OP_ADD, 3'd3, 3'd2),  1'b1, 3'd2, 16'h1234, 16'h1235, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[2]  = '{16'h0004, 16'h0001, 16'h0002, enc_r(OP_SUB, 3'd1, 3'd2),  1'b0, 3'd0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[3]  = '{16'h0020, 16'h5555, 16'h0000, enc_j(OP_JN, 11'd4),        1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 1'b1, 16'h002A, 1'b0, 1'b1};
    vt[4]  = '{16'h0008, 16'h0007, 16'h0007, enc_r(OP_CMP, 3'd1, 3'd1),  1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[5]  = '{16'h0010, 16'h0000, 16'h0000, enc_j(OP_JZ, 11'h7FE),      1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h000E, 1'b1, 1'b0};
    vt[6]  = '{16'h0010, 16'h0000, 16'h0000, enc_j(OP_JN, 11'h7FE),      1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[7]  = '{16'h0100, 16'h0200, 16'h0000, enc_r(OP_CALLR, 3'd4, 3'd0), 1'b0, 3'd0, 16'h0000, 16'h0102, 16'h0102, 16'h0200, 1'b1, 16'h0200, 1'b1, 1'b0};
    vt[8]  = '{16'h0102, 16'h1234, 16'h0000, enc_i(OP_MVHI, 3'd1, 8'hAB), 1'b0, 3'd0, 16'h0000, 16'hAB34, 16'hAB34, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[9]  = '{16'h0104, 16'h0000, 16'h0000, enc_i(OP_MVI, 3'd1, 8'h80),  1'b0, 3'd0, 16'h0000, 16'hFF80, 16'hFF80, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[10] = '{16'h0106, 16'h0010, 16'h0000, enc_r(OP_JZR, 3'd5, 3'd0),  1'b1, 3'd5, 16'h0300, 16'h0000, 16'h0000, 16'h0300, 1'b1, 16'h0300, 1'b1, 1'b0};
    vt[11] = '{16'h0300, 16'h0000, 16'h0000, enc_i(OP_SUBI, 3'd2, 8'hFF), 1'b0, 3'd0, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vt[12] = '{16'h0302, 16'h8000, 16'h8000, enc_r(OP_ADD, 3'd1, 3'd2),  1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[13] = '{16'h1000, 16'h0000, 16'h0000, enc_j(OP_JZ, 11'h400),      1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0802, 1'b1, 1'b0};

    // Reset with a pending stalled load on the inputs: nothing may be requested.
    reset   = 1'b0;
    rf_ex   = {16'h0000, 16'h0000, 16'h0040, enc_r(OP_LD, 3'd1, 3'd2)};
    valid   = 1'b1;
    wb_we   = 1'b0;
    wb_reg  = 3'd0;
    wb_data = 16'h0000;
    waitreq = 1'b1;
    @(posedge clk); #1;
    #4;
    chk("reset_rd", 64'(bus.rd), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_taken", 64'(br_taken), 64'd0);
    @(posedge clk); #1;
    chk("reset_exwb", ex_wb, 64'd0);
    chk("reset_valid", 64'(ex_wb_valid), 64'd0);
    chk("reset_z", 64'(flag_z), 64'd0);
    chk("reset_n", 64'(flag_n), 64'd0);
    $display("reset: exwb=%h valid=%0d z=%0d n=%0d", ex_wb, ex_wb_valid, flag_z, flag_n);
    reset   = 1'b1;
    valid   = 1'b0;
    waitreq = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      rf_ex   = {vt[i].pc, vt[i].d1, vt[i].d2, vt[i].instr};
      valid   = 1'b1;
      wb_we   = vt[i].we;
      wb_reg  = vt[i].wreg;
      wb_data = vt[i].wdata;
      #4;
      chk($sformatf("vec%0d_taken", i), 64'(br_taken), 64'(vt[i].e_taken));
      if (vt[i].e_taken) chk($sformatf("vec%0d_target", i), 64'(br_target), 64'(vt[i].e_tgt));
      chk($sformatf("vec%0d_stall", i), 64'(stall), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 64'(ex_wb_valid), 64'd1);
      chk($sformatf("vec%0d_alu", i), 64'(ex_wb[31:16]), 64'(vt[i].e_alu));
      chk($sformatf("vec%0d_rx", i), 64'(ex_wb[63:48]), 64'(vt[i].e_rx));
      chk($sformatf("vec%0d_instr", i), 64'(ex_wb[15:0]), 64'(vt[i].instr));
      chk($sformatf("vec%0d_z", i), 64'(flag_z), 64'(vt[i].e_z));
      chk($sformatf("vec%0d_n", i), 64'(flag_n), 64'(vt[i].e_n));
      chk($sformatf("vec%0d_alu_nofwd", i), 64'(ex_wb0[31:16]), 64'(vt[i].e_alu_nofwd));
      $display("vec%0d: instr=%h alu=%h taken=%0d target=%h z=%0d n=%0d",
               i, vt[i].instr, ex_wb[31:16], vt[i].e_taken, vt[i].e_tgt, flag_z, flag_n);
    end
    wb_we = 1'b0;

    // Bubble: no live instruction gives a zero payload and keeps the flags.
    valid = 1'b0;
    @(posedge clk); #1;
    chk("bubble_valid", 64'(ex_wb_valid), 64'd0);
    chk("bubble_exwb", ex_wb, 64'd0);
    chk("bubble_z_hold", 64'(flag_z), 64'd1);
    $display("bubble: valid=%0d exwb=%h", ex_wb_valid, ex_wb);

    // ld r1,[r2] with 3 waitrequest cycles; WB traffic during the wait must not move the address.
    rf_ex   = {16'h0200, 16'h0000, 16'h0040, enc_r(OP_LD, 3'd1, 3'd2)};
    valid   = 1'b1;
    waitreq = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      chk($sformatf("ld_c%0d_rd", c), 64'(bus.rd), 64'd1);
      chk($sformatf("ld_c%0d_addr", c), 64'(bus.addr), 64'h0040);
      chk($sformatf("ld_c%0d_stall", c), 64'(stall), 64'(c < 3));
      @(posedge clk); #1;
      chk($sformatf("ld_c%0d_valid", c), 64'(ex_wb_valid), 64'(c == 3));
      if (c == 3) chk("ld_commit_alu", 64'(ex_wb[31:16]), 64'h0040);
      $display("ld cycle %0d: addr=%h stall=%0d exwb_valid=%0d", c, bus.addr, stall, ex_wb_valid);
      wb_we   = 1'b1;
      wb_reg  = 3'd2;
      wb_data = 16'h9999;
      waitreq = (c < 2);
    end
    wb_we = 1'b0;

    // st stalls, then reset lands while it waits.
    rf_ex   = {16'h0202, 16'hABCD, 16'h0080, enc_r(OP_ST, 3'd3, 3'd2)};
    valid   = 1'b1;
    waitreq = 1'b1;
    #4;
    chk("st_wr", 64'(bus.wr), 64'd1);
    chk("st_wrdata", 64'(bus.wrdata), 64'hABCD);
    chk("st_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #4;
    chk("st_rst_wr", 64'(bus.wr), 64'd0);
    chk("st_rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("st_rst_valid", 64'(ex_wb_valid), 64'd0);
    chk("st_rst_z", 64'(flag_z), 64'd0);
    chk("st_rst_n", 64'(flag_n), 64'd0);
    $display("st reset: wr=%0d stall=%0d valid=%0d z=%0d", bus.wr, stall, ex_wb_valid, flag_z);
    reset   = 1'b1;
    rf_ex   = {16'h0300, 16'h1111, 16'h0022, enc_r(OP_ST, 3'd3, 3'd2)};
    waitreq = 1'b0;
    #4;
    chk("post_rst_addr", 64'(bus.addr), 64'h0022);
    chk("post_rst_wrdata", 64'(bus.wrdata), 64'h1111);
    chk("post_rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("post_rst_valid", 64'(ex_wb_valid), 64'd1);
    $display("post reset st: addr=%h wrdata=%h valid=%0d", bus.addr, bus.wrdata, ex_wb_valid);

    // Randomized instructions against the reference model.
    mz = 1'b0;
    mn = 1'b0;
    for (int it = 0; it < 250; it++) begin
      r_v   = ($urandom_range(0, 9) != 0);
      r_pc  = 16'($urandom());
      r_d1  = 16'($urandom());
      r_d2  = 16'($urandom());
      r_ins = 16'($urandom());
      r_ins[4:0] = ops[$urandom_range(0, 18)];
      r_we  = ($urandom_range(0, 1) == 1);
      r_wr  = 3'($urandom());
      r_wd  = 16'($urandom());
      m     = model(r_pc, r_d1, r_d2, r_ins, r_we, r_wr, r_wd, mz, mn);
      waits = (r_v && (m.is_ld || m.is_st)) ? $urandom_range(0, 2) : 0;
      rf_ex   = {r_pc, r_d1, r_d2, r_ins};
      valid   = r_v;
      wb_we   = r_we;
      wb_reg  = r_wr;
      wb_data = r_wd;
      waitreq = (waits > 0);
      for (int c = 0; c <= waits; c++) begin
        #4;
        chk("rnd_stall", 64'(stall), 64'(c < waits));
        chk("rnd_rd", 64'(bus.rd), 64'(r_v && m.is_ld));
        chk("rnd_wr", 64'(bus.wr), 64'(r_v && m.is_st));
        if (r_v && (m.is_ld || m.is_st)) begin
          chk("rnd_addr", 64'(bus.addr), 64'(m.ry));
          chk("rnd_wrdata", 64'(bus.wrdata), 64'(m.rx));
        end
        if (c == 0) begin
          chk("rnd_taken", 64'(br_taken), 64'(r_v && m.taken));
          if (r_v && m.taken) chk("rnd_target", 64'(br_target), 64'(m.target));
        end
        @(posedge clk); #1;
        if (c < waits) begin
          chk("rnd_wait_valid", 64'(ex_wb_valid), 64'd0);
          wb_we   = 1'b1;
          wb_reg  = 3'($urandom());
          wb_data = 16'($urandom());
          waitreq = (c + 1 < waits);
        end else if (r_v) begin
          mz = m.z;
          mn = m.n;
          chk("rnd_valid", 64'(ex_wb_valid), 64'd1);
          chk("rnd_exwb", ex_wb, {m.rx, m.ry, m.alu, r_ins});
          chk("rnd_z", 64'(flag_z), 64'(mz));
          chk("rnd_n", 64'(flag_n), 64'(mn));
        end else begin
          chk("rnd_bubble_valid", 64'(ex_wb_valid), 64'd0);
          chk("rnd_bubble_exwb", ex_wb, 64'd0);
        end
      end
      $display("rnd%0d: v=%0d instr=%h waits=%0d alu=%h taken=%0d z=%0d n=%0d",
               it, r_v, r_ins, waits, m.alu, m.taken, mz, mn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
